alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined ALU. It replaces the combinational 2-bit-opcode ALU with an 8-operation, flag-producing datapath.
- Valid/ready handshakes on both input and output, with full backpressure and no bubbles at steady state.
- A saturating completed-operation counter gives the detection testbenches a golden activity reference against which to compare tampered variants.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_core.sv | 78 +++++++
 rtl/alu_pipe.sv | 107 ++++++++++
 tb/tb_alu_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag-vector layout for the pipelined ALU.
// The flag vector is ordered {zero, negative, carry, overflow}.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam int FLAG_W     = 4;
  localparam int FLAG_ZERO  = 3;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: eight operations producing a result and
// the {zero, negative, carry, overflow} flag vector.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic [2:0]        i_opcode,
  output logic [WIDTH-1:0]  o_y,
  output logic [FLAG_W-1:0] o_flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_sh;
  logic [SHW-1:0]   w_sh_m1;
  logic [WIDTH-1:0] w_shl_pre;
  logic [WIDTH-1:0] w_shr_pre;
  logic [WIDTH-1:0] w_y;
  logic             w_carry;
  logic             w_ovf;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // The extra MSB of the difference is the borrow, i.e. a < b unsigned.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  assign w_sh    = i_b[SHW-1:0];
  assign w_sh_m1 = w_sh - SHW'(1);
  // Shifting by one less than the amount puts the last bit shifted out
  // at the edge of the word, which gives the shift carry directly.
  assign w_shl_pre = i_a << w_sh_m1;
  assign w_shr_pre = i_a >> w_sh_m1;

  always_comb begin
    w_y     = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        w_y     = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_y[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_y     = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_y[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_AND: w_y = i_a & i_b;
      OP_OR:  w_y = i_a | i_b;
      OP_XOR: w_y = i_a ^ i_b;
      OP_SHL: begin
        w_y     = i_a << w_sh;
        w_carry = (w_sh != '0) ? w_shl_pre[WIDTH-1] : 1'b0;
      end
      OP_SHR: begin
        w_y     = i_a >> w_sh;
        w_carry = (w_sh != '0) ? w_shr_pre[0] : 1'b0;
      end
      default: w_y = i_a;
    endcase
  end

  always_comb begin
    o_flags             = '0;
    o_flags[FLAG_ZERO]  = (w_y == '0);
    o_flags[FLAG_NEG]   = w_y[WIDTH-1];
    o_flags[FLAG_CARRY] = w_carry;
    o_flags[FLAG_OVF]   = w_ovf;
  end

  assign o_y = w_y;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides and a
// saturating count of completed output transfers.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     y,
  output logic                 zero,
  output logic                 negative,
  output logic                 carry,
  output logic                 overflow,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] op_count
);

  logic                 r_s1_valid;
  logic [WIDTH-1:0]     r_s1_a;
  logic [WIDTH-1:0]     r_s1_b;
  logic [2:0]           r_s1_op;
  logic                 r_s2_valid;
  logic [WIDTH-1:0]     r_s2_y;
  logic [FLAG_W-1:0]    r_s2_flags;
  logic [CNT_WIDTH-1:0] r_op_count;

  logic                 w_s2_load;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic [WIDTH-1:0]     w_core_y;
  logic [FLAG_W-1:0]    w_core_flags;

  // s1 may advance whenever s2 is empty or draining this cycle.
  assign w_s2_load  = r_s1_valid & (!r_s2_valid | out_ready);
  assign in_ready   = !r_s1_valid | w_s2_load;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_s2_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= a;
      r_s1_b     <= b;
      r_s1_op    <= opcode;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .i_opcode (r_s1_op),
    .o_y      (w_core_y),
    .o_flags  (w_core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_y     <= '0;
      r_s2_flags <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_s2_y     <= w_core_y;
      r_s2_flags <= w_core_flags;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  // Clear has priority over a same-cycle increment; the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (cnt_clr) begin
      r_op_count <= '0;
    end else if (w_out_fire && (r_op_count != '1)) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign out_valid = r_s2_valid;
  assign y         = r_s2_y;
  assign zero      = r_s2_flags[FLAG_ZERO];
  assign negative  = r_s2_flags[FLAG_NEG];
  assign carry     = r_s2_flags[FLAG_CARRY];
  assign overflow  = r_s2_flags[FLAG_OVF];
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and random bench for alu_pipe: scoreboard of modelled results,
// latency, backpressure, counter saturation/clear and asynchronous reset.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic       cnt_clr;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;

  logic        in_ready, out_valid, zero, negative, carry, overflow;
  logic [7:0]  y;
  logic [15:0] op_count;

  logic        in_ready4, out_valid4, zero4, negative4, carry4, overflow4;
  logic [7:0]  y4;
  logic [3:0]  op_count4;

  int checks = 0;
  int errors = 0;
  logic [11:0] q[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
    .cnt_clr(cnt_clr), .op_count(op_count)
  );

  alu_pipe #(.WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid4), .out_ready(out_ready),
    .y(y4), .zero(zero4), .negative(negative4), .carry(carry4), .overflow(overflow4),
    .cnt_clr(cnt_clr), .op_count(op_count4)
  );

  // Reference model: returns {y, zero, negative, carry, overflow}.
  function automatic logic [11:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic [2:0] mop);
    int sa, sb, r, sh;
    logic [7:0] ry;
    logic c, v;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    sh = int'(mb[2:0]);
    c  = 1'b0;
    v  = 1'b0;
    ry = 8'd0;
    case (mop)
      3'd0: begin
        r  = int'(ma) + int'(mb);
        ry = r[7:0];
        c  = (r > 255);
        v  = (sa + sb > 127) || (sa + sb < -128);
      end
      3'd1: begin
        r  = int'(ma) - int'(mb);
        ry = r[7:0];
        c  = (ma < mb);
        v  = (sa - sb > 127) || (sa - sb < -128);
      end
      3'd2: ry = ma & mb;
      3'd3: ry = ma | mb;
      3'd4: ry = ma ^ mb;
      3'd5: begin
        ry = ma << sh;
        c  = (sh != 0) ? ma[8-sh] : 1'b0;
      end
      3'd6: begin
        ry = ma >> sh;
        c  = (sh != 0) ? ma[sh-1] : 1'b0;
      end
      default: ry = ma;
    endcase
    return {ry, (ry == 8'd0), ry[7], c, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard pops/pushes at the falling edge, inputs change after the rise.
  task automatic tick();
    logic [11:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_y", 32'(y), 32'(e[11:4]));
        chk("sb_flags", 32'({zero, negative, carry, overflow}), 32'(e[3:0]));
      end
    end
    if (in_valid && in_ready) q.push_back(model(a, b, opcode));
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string tag, input logic [2:0] op, input logic [7:0] xa,
                        input logic [7:0] xb, input logic [7:0] ey, input logic [3:0] ef);
    opcode   = op;
    a        = xa;
    b        = xb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid_early"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_y"}, 32'(y), 32'(ey));
    chk({tag, "_flags"}, 32'({zero, negative, carry, overflow}), 32'(ef));
    tick();
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      a        = 8'($urandom);
      b        = 8'($urandom);
      opcode   = 3'($urandom_range(0, 7));
      in_valid = 1'b1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      if (i > 0) chk("stream_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("stream_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    a         = 8'd0;
    b         = 8'd0;
    opcode    = 3'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_flags", 32'({zero, negative, carry, overflow}), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed single operations, flags as {zero, negative, carry, overflow}
    single("add_ovf",   3'd0, 8'h7F, 8'h01, 8'h80, 4'b0101);
    single("add_carry", 3'd0, 8'hFF, 8'h01, 8'h00, 4'b1010);
    single("sub_borrow", 3'd1, 8'h03, 8'h05, 8'hFE, 4'b0110);
    single("shl_1",     3'd5, 8'h81, 8'h01, 8'h02, 4'b0010);
    single("shr_1",     3'd6, 8'h01, 8'h01, 8'h00, 4'b1010);
    single("shl_0",     3'd5, 8'h5A, 8'h08, 8'h5A, 4'b0000);
    chk("single_count", 32'(op_count), 32'd6);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_count", 32'(op_count), 32'd0);

    stream(100);
    chk("stream_count", 32'(op_count), 32'd100);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    stream(20);
    chk("sat_count4", 32'(op_count4), 32'd15);
    chk("count20", 32'(op_count), 32'd20);

    // Backpressure: fill both stages, then hold a third op against a stalled output
    out_ready = 1'b0;
    opcode = 3'd0; a = 8'h7F; b = 8'h01; in_valid = 1'b1;
    tick();
    opcode = 3'd1; a = 8'h10; b = 8'h20;
    tick();
    opcode = 3'd4; a = 8'hA5; b = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_y_hold", 32'(y), 32'h80);
      chk("bp_flags_hold", 32'({zero, negative, carry, overflow}), 32'b0101);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("bp_drained", 32'(q.size()), 32'd0);
    chk("bp_out_valid_end", 32'(out_valid), 32'd0);
    chk("bp_count", 32'(op_count), 32'd23);

    // Clear coinciding with an output handshake
    opcode = 3'd3; a = 8'h0F; b = 8'hF0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr_hs_valid", 32'(out_valid), 32'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_hs_count", 32'(op_count), 32'd0);
    chk("clr_hs_count4", 32'(op_count4), 32'd0);

    // Asynchronous reset with both stages occupied
    stream(3);
    out_ready = 1'b0;
    opcode = 3'd2; a = 8'hFF; b = 8'h3C; in_valid = 1'b1;
    tick();
    opcode = 3'd7; a = 8'h99;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_count", 32'(op_count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_y", 32'(y), 32'd0);
    chk("arst_flags", 32'({zero, negative, carry, overflow}), 32'd0);
    chk("arst_op_count", 32'(op_count), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    single("post_rst_and", 3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000);
    chk("post_rst_count", 32'(op_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
